// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    FETCH,
    DATA
  } grant_t;

  localparam int unsigned MEM_ARB_TIMEOUT = 255;
  localparam int unsigned PERF_CNT_W      = 32;

endpackage

// File: rtl/mem_arb_perf.sv
// Saturating performance counters for the memory port arbiter.
// Instantiated only when MEM_ARB_PERF_EN is defined.
module mem_arb_perf
  import mem_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_stall_f,
  input  logic                  i_stall_m,
  input  logic                  i_conflict,
  output logic [PERF_CNT_W-1:0] o_perf_fetch_stall,
  output logic [PERF_CNT_W-1:0] o_perf_data_stall,
  output logic [PERF_CNT_W-1:0] o_perf_conflict
);

  logic [PERF_CNT_W-1:0] r_fetch_stall;
  logic [PERF_CNT_W-1:0] r_data_stall;
  logic [PERF_CNT_W-1:0] r_conflict;

  // Count event cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_stall <= '0;
      r_data_stall  <= '0;
      r_conflict    <= '0;
    end else begin
      if (i_stall_f && (r_fetch_stall != '1)) r_fetch_stall <= r_fetch_stall + 1'b1;
      if (i_stall_m && (r_data_stall  != '1)) r_data_stall  <= r_data_stall  + 1'b1;
      if (i_conflict && (r_conflict   != '1)) r_conflict    <= r_conflict    + 1'b1;
    end
  end

  assign o_perf_fetch_stall = r_fetch_stall;
  assign o_perf_data_stall  = r_data_stall;
  assign o_perf_conflict    = r_conflict;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data
// load/store. Each access runs IDLE -> ISSUE -> WAIT -> RESP; a WAIT that
// exceeds TIMEOUT cycles aborts with zero data and sets the sticky mem_err.
// Optional: MEM_ARB_PERF_EN adds stall/conflict counters as output ports.
// ASSERT_EN enables checks that requesters hold req until their ack.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = MEM_ARB_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  input  logic                flush,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_F,
  output logic                stall_M,
  output logic                mem_err
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]         perf_fetch_stall,
  output logic [31:0]         perf_data_stall,
  output logic [31:0]         perf_conflict
`endif
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t          r_state;
  grant_t              r_grant;
  grant_t              r_last_grant;
  logic                r_drop;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_mem_valid;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W/8-1:0] r_mem_be;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_if_ack;
  logic                r_d_ack;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                r_mem_err;

  logic w_if_pend;
  logic w_d_pend;
  logic w_pick_data;
  logic w_fetch_flush;

  // A request whose ack is visible this cycle has just completed; masking it
  // keeps the requester's still-high req from being granted a second time.
  assign w_if_pend     = if_req && !flush && !r_if_ack;
  assign w_d_pend      = d_req && !r_d_ack;
  assign w_pick_data   = w_d_pend && !(w_if_pend && (r_last_grant == DATA));
  assign w_fetch_flush = (r_grant == FETCH) && flush;

  // Transaction sequencer with registered memory request and ack outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_grant      <= FETCH;
      r_last_grant <= FETCH;
      r_drop       <= 1'b0;
      r_cnt        <= '0;
      r_mem_valid  <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_be     <= '0;
      r_rdata      <= '0;
      r_if_ack     <= 1'b0;
      r_d_ack      <= 1'b0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
      r_mem_err    <= 1'b0;
    end else begin
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_d_pend || w_if_pend) begin
            r_mem_valid <= 1'b1;
            r_state     <= ISSUE;
            if (w_pick_data) begin
              r_grant     <= DATA;
              r_mem_we    <= d_we;
              r_mem_addr  <= d_addr;
              r_mem_wdata <= d_wdata;
              r_mem_be    <= d_be;
            end else begin
              r_grant     <= FETCH;
              r_mem_we    <= 1'b0;
              r_mem_addr  <= if_addr;
              r_mem_wdata <= '0;
              r_mem_be    <= '1;
            end
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            r_mem_valid <= 1'b0;
            r_cnt       <= '0;
            r_state     <= WAIT;
            // Already accepted: the response must still be consumed.
            if (w_fetch_flush) r_drop <= 1'b1;
          end else if (w_fetch_flush) begin
            r_mem_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_fetch_flush) r_drop <= 1'b1;
          if (mem_rvalid) begin
            r_rdata <= mem_rdata;
            r_state <= RESP;
          end else if (r_cnt == CNT_LAST) begin
            r_mem_err <= 1'b1;
            r_rdata   <= '0;
            r_state   <= RESP;
          end
        end
        RESP: begin
          if (!r_drop) begin
            if (r_grant == FETCH) begin
              r_if_ack   <= 1'b1;
              r_if_rdata <= r_rdata;
            end else begin
              r_d_ack   <= 1'b1;
              r_d_rdata <= r_rdata;
            end
          end
          r_last_grant <= r_grant;
          r_drop       <= 1'b0;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign if_ack    = r_if_ack;
  assign if_rdata  = r_if_rdata;
  assign d_ack     = r_d_ack;
  assign d_rdata   = r_d_rdata;
  assign mem_valid = r_mem_valid;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;
  assign mem_err   = r_mem_err;
  assign stall_F   = if_req && !if_ack;
  assign stall_M   = d_req && !d_ack;

`ifdef MEM_ARB_PERF_EN
  logic w_conflict;
  assign w_conflict = (r_state == IDLE) && w_if_pend && w_d_pend;

  mem_arb_perf u_perf (
    .clk                (clk),
    .rst                (rst),
    .i_stall_f          (stall_F),
    .i_stall_m          (stall_M),
    .i_conflict         (w_conflict),
    .o_perf_fetch_stall (perf_fetch_stall),
    .o_perf_data_stall  (perf_data_stall),
    .o_perf_conflict    (perf_conflict)
  );
`endif

`ifdef ASSERT_EN
  // Fetch may abandon its request only together with a flush.
  a_if_hold: assert property (@(posedge clk) disable iff (rst)
    (if_req && !if_ack && !flush) |=> (if_req || flush));
  a_d_hold: assert property (@(posedge clk) disable iff (rst)
    (d_req && !d_ack) |=> d_req);
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter with a simple memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        flush;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata  = '0;
  logic        stall_F;
  logic        stall_M;
  logic        mem_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_rdata(d_rdata), .flush(flush),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall_F(stall_F), .stall_M(stall_M), .mem_err(mem_err)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Memory model state
  logic [31:0] mem_a [logic [31:0]];
  bit          pend    = 1'b0;
  int          dly     = 0;
  int          resp_dly = 0;
  bit          resp_en = 1'b1;
  int          n_acc   = 0;
  logic        p_we, acc_we;
  logic [31:0] p_addr, p_wdata, acc_addr, acc_wdata;
  logic [3:0]  p_be, acc_be;

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem_a.exists(a)) return mem_a[a];
    return ~a;
  endfunction

  // Memory: accepts on valid&&ready, answers resp_dly cycles later.
  always @(posedge clk) begin
    logic [31:0] nw;
    if (!rst && mem_valid && mem_ready) begin
      pend = 1'b1; dly = resp_dly;
      p_we = mem_we; p_addr = mem_addr; p_wdata = mem_wdata; p_be = mem_be;
      acc_we = mem_we; acc_addr = mem_addr; acc_wdata = mem_wdata; acc_be = mem_be;
      n_acc++;
    end
    #1;
    mem_rvalid = 1'b0;
    if (rst) pend = 1'b0;
    else if (pend) begin
      if (dly == 0) begin
        pend = 1'b0;
        if (resp_en) begin
          mem_rvalid = 1'b1;
          if (p_we) begin
            nw = rd(p_addr);
            for (int b = 0; b < 4; b++)
              if (p_be[b]) nw[b*8 +: 8] = p_wdata[b*8 +: 8];
            mem_a[p_addr] = nw;
          end else begin
            mem_rdata = rd(p_addr);
          end
        end
      end else begin
        dly--;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One transaction starting at a negedge; checks latency, stalls, data, fields.
  task automatic txn(input bit is_d, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     input bit chk_rd, input logic [31:0] exp_rd,
                     input int exp_lat, input string name);
    int lat;
    lat = -1;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_be = be;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (is_d ? d_ack : if_ack) begin
        lat = c;
        break;
      end
      check({name, "_stall_hi"}, 32'(is_d ? stall_M : stall_F), 32'd1);
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    if (lat > 0) begin
      check({name, "_stall_lo"}, 32'(is_d ? stall_M : stall_F), 32'd0);
      if (chk_rd) check({name, "_rdata"}, is_d ? d_rdata : if_rdata, exp_rd);
      check({name, "_mem_addr"}, acc_addr, addr);
      check({name, "_mem_we"}, 32'(acc_we), 32'(we));
      if (we) begin
        check({name, "_mem_wdata"}, acc_wdata, wdata);
        check({name, "_mem_be"}, 32'(acc_be), 32'(be));
      end
    end
    if (is_d) d_req = 1'b0; else if_req = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    bit          chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int  a0;
    bit  seen;
    logic [1:0] exp_ack;

    vt[0] = '{1'b0, 1'b0, 32'h100,  32'h0,        4'h0, 1'b1, 32'h00500093};
    vt[1] = '{1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0};
    vt[2] = '{1'b1, 1'b0, 32'h2000, 32'h0,        4'h0, 1'b1, 32'hDEADBEEF};
    vt[3] = '{1'b1, 1'b1, 32'h2000, 32'h11223344, 4'h3, 1'b0, 32'h0};
    vt[4] = '{1'b0, 1'b0, 32'h104,  32'h0,        4'h0, 1'b1, 32'h00A00113};
    vt[5] = '{1'b1, 1'b0, 32'h2000, 32'h0,        4'h0, 1'b1, 32'hDEAD3344};

    mem_a[32'h100] = 32'h00500093;
    mem_a[32'h104] = 32'h00A00113;
    mem_a[32'h200] = 32'h00000013;
    mem_a[32'h300] = 32'h12345678;

    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_be = '0; flush = 1'b0; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_if_ack", 32'(if_ack), 32'd0);
    check("rst_d_ack", 32'(d_ack), 32'd0);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_mem_err", 32'(mem_err), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Both held from reset: data first, then alternating every transaction.
    if_req = 1'b1; if_addr = 32'h300; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      exp_ack = (c == 4 || c == 12) ? 2'b01 : (c == 8 || c == 16) ? 2'b10 : 2'b00;
      check($sformatf("alt_acks_c%0d", c), 32'({if_ack, d_ack}), 32'(exp_ack));
      if (c == 8) check("alt_if_rdata", if_rdata, 32'h12345678);
    end
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      txn(vt[i].is_d, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be,
          vt[i].chk_rd, vt[i].exp_rd, 4, $sformatf("vec%0d", i));

    // Last grant was DATA: simultaneous requests now go to fetch first.
    if_req = 1'b1; if_addr = 32'h100; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      exp_ack = (c == 4) ? 2'b10 : (c == 8) ? 2'b01 : 2'b00;
      check($sformatf("rr_acks_c%0d", c), 32'({if_ack, d_ack}), 32'(exp_ack));
      if (c == 4) if_req = 1'b0;
    end
    d_req = 1'b0;
    check("rr_if_rdata", if_rdata, 32'h00500093);
    check("rr_d_rdata", d_rdata, 32'hDEAD3344);
    @(negedge clk);

    // Flush while the fetch is in WAIT: response consumed, no ack.
    resp_dly = 3; a0 = n_acc; seen = 1'b0;
    if_req = 1'b1; if_addr = 32'h180;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1; if_req = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (if_ack) seen = 1'b1;
      @(negedge clk);
    end
    check("flw_no_ack", 32'(seen), 32'd0);
    check("flw_one_access", 32'(n_acc - a0), 32'd1);
    check("flw_rdata_held", if_rdata, 32'h00500093);
    resp_dly = 0;
    txn(1'b0, 1'b0, 32'h200, 32'h0, 4'h0, 1'b1, 32'h00000013, 4, "after_flush");

    // Flush during ISSUE with memory not ready: request withdrawn.
    mem_ready = 1'b0; a0 = n_acc; seen = 1'b0;
    if_req = 1'b1; if_addr = 32'h400;
    @(negedge clk);
    check("fli_valid_hi", 32'(mem_valid), 32'd1);
    flush = 1'b1; if_req = 1'b0;
    @(negedge clk);
    check("fli_valid_lo", 32'(mem_valid), 32'd0);
    flush = 1'b0; mem_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (if_ack || mem_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("fli_quiet", 32'(seen), 32'd0);
    check("fli_no_access", 32'(n_acc - a0), 32'd0);

    // No response: abort after 8 WAIT cycles with zero data and mem_err.
    check("to_err_before", 32'(mem_err), 32'd0);
    resp_en = 1'b0;
    txn(1'b1, 1'b0, 32'h2000, 32'h0, 4'h0, 1'b1, 32'h0, 11, "timeout");
    check("to_err_set", 32'(mem_err), 32'd1);
    resp_en = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("to_err_cleared", 32'(mem_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    txn(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 1'b1, 32'h00500093, 4, "post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
